// File: rtl/fisr_pkg.sv
// fisr_pkg: shared float-format constants, flag layout and types for the fast inverse square root pipeline
package fisr_pkg;
    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FLG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;
    localparam logic [FP_W-1:0]  POS_INF = 32'h7F800000;

    localparam int FLG_ZERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_INF  = 2;
    localparam int FLG_NAN  = 3;

    typedef logic [FP_W-1:0]  fp_t;
    typedef logic [FLG_W-1:0] flags_t;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: one-hot special-operand classification of an IEEE-754 single (denormals count as zero)
module fp_classify
    import fisr_pkg::*;
(
    input  fp_t    data_i,
    output flags_t flags_o
);
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             zero, nan, inf, neg;

    assign s    = data_i[FP_W-1];
    assign e    = data_i[FP_W-2 -: EXP_W];
    assign m    = data_i[MAN_W-1:0];
    assign zero = (e == '0);
    assign nan  = (e == EXP_MAX) && (m != '0);
    assign inf  = (e == EXP_MAX) && (m == '0) && !s;
    assign neg  = s && !zero && !nan;

    // pack the class bits into their fixed flag positions
    always_comb begin
        flags_o           = '0;
        flags_o[FLG_ZERO] = zero;
        flags_o[FLG_NEG]  = neg;
        flags_o[FLG_INF]  = inf;
        flags_o[FLG_NAN]  = nan;
    end
endmodule

// File: rtl/fisr_initial_guess.sv
// fisr_initial_guess: two-stage handshaked front end producing x/2 and the magic-constant seed for Newton refinement
module fisr_initial_guess
    import fisr_pkg::*;
#(
    parameter logic [FP_W-1:0] MAGIC = 32'h5F3759DF,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  Data_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic [FP_W-1:0]  Data_out1,
    output logic [FP_W-1:0]  Data_out2,
    output logic [FLG_W-1:0] Flags_out,
    output logic             Valid_out,
    input  logic             Ready_in,
    output logic [CNT_W-1:0] Count_out
);
    logic             v1_q, v2_q;
    fp_t              x1_q, x2_q, y0_q, x2_d, y0_d, norm_x2;
    flags_t           f1_q, f2_q, flags_d;
    logic [EXP_W-1:0] e1;
    logic [CNT_W-1:0] cnt_q;
    logic             adv1, adv2;

    fp_classify u_cls (
        .data_i  (Data_in),
        .flags_o (flags_d)
    );

    assign adv2      = !v2_q || Ready_in;
    assign adv1      = !v1_q || adv2;
    assign Ready_out = adv1;
    assign Valid_out = v2_q;
    assign Data_out1 = x2_q;
    assign Data_out2 = y0_q;
    assign Flags_out = f2_q;
    assign Count_out = cnt_q;
    assign e1        = x1_q[FP_W-2 -: EXP_W];

    // halve by decrementing the exponent, flushing the min-normal case, and override specials
    always_comb begin
        norm_x2 = (e1 == 8'd1) ? '0 : {x1_q[FP_W-1], e1 - 8'd1, x1_q[MAN_W-1:0]};
        x2_d    = f1_q[FLG_ZERO] ? '0 :
                  f1_q[FLG_INF] ? x1_q :
                  (f1_q[FLG_NAN] || f1_q[FLG_NEG]) ? QNAN : norm_x2;
        y0_d    = f1_q[FLG_ZERO] ? POS_INF :
                  f1_q[FLG_INF] ? '0 :
                  (f1_q[FLG_NAN] || f1_q[FLG_NEG]) ? QNAN : MAGIC - {1'b0, x1_q[FP_W-1:1]};
    end

    // stage 1: capture operand and class flags whenever the stage can move
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            x1_q <= '0;
            f1_q <= '0;
        end else if (adv1) begin
            v1_q <= Valid_in;
            if (Valid_in) begin
                x1_q <= Data_in;
                f1_q <= flags_d;
            end
        end
    end

    // stage 2: register final words; held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            x2_q <= '0;
            y0_q <= '0;
            f2_q <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                x2_q <= x2_d;
                y0_q <= y0_d;
                f2_q <= f1_q;
            end
        end
    end

    // count completed output handshakes, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (v2_q && Ready_in) cnt_q <= cnt_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_fisr_initial_guess.sv
// tb_fisr_initial_guess: directed vectors with hand-computed results, scoreboarded through the handshake
module tb_fisr_initial_guess;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Data_in;
    logic        Valid_in;
    logic        Ready_out;
    logic [31:0] Data_out1;
    logic [31:0] Data_out2;
    logic [3:0]  Flags_out;
    logic        Valid_out;
    logic        Ready_in;
    logic [15:0] Count_out;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;
    int          q[$];

    localparam int NV = 15;
    logic [31:0] vx  [NV] = '{32'h40800000, 32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7F800000,
                              32'h7FC00001, 32'h00000001, 32'h00800000, 32'h80000000, 32'hFF800000,
                              32'h40000000, 32'h40400000, 32'h41000000, 32'h41800000, 32'hFFC00000};
    logic [31:0] vx2 [NV] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
                              32'h7FC00000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                              32'h3F800000, 32'h3FC00000, 32'h40800000, 32'h41000000, 32'h7FC00000};
    logic [31:0] vy0 [NV] = '{32'h3EF759DF, 32'h3F7759DF, 32'h7F800000, 32'h7FC00000, 32'h00000000,
                              32'h7FC00000, 32'h7F800000, 32'h5EF759DF, 32'h7F800000, 32'h7FC00000,
                              32'h3F3759DF, 32'h3F1759DF, 32'h3EB759DF, 32'h3E7759DF, 32'h7FC00000};
    logic [3:0]  vf  [NV] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h1, 4'h2,
                              4'h0, 4'h0, 4'h0, 4'h0, 4'h8};

    fisr_initial_guess dut (
        .clk       (clk),
        .rst       (rst),
        .Data_in   (Data_in),
        .Valid_in  (Valid_in),
        .Ready_out (Ready_out),
        .Data_out1 (Data_out1),
        .Data_out2 (Data_out2),
        .Flags_out (Flags_out),
        .Valid_out (Valid_out),
        .Ready_in  (Ready_in),
        .Count_out (Count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    endtask

    // outputs compared against the oldest accepted vector every cycle they are valid, popped on transfer
    always @(negedge clk) begin
        if (!rst && Valid_out) begin
            if (q.size() == 0) chk("spurious_valid", 32'(Valid_out), 32'd0);
            else begin
                chk($sformatf("x2[%0d]", q[0]), Data_out1, vx2[q[0]]);
                chk($sformatf("y0[%0d]", q[0]), Data_out2, vy0[q[0]]);
                chk($sformatf("flags[%0d]", q[0]), 32'(Flags_out), 32'(vf[q[0]]));
                if (Ready_in) begin
                    void'(q.pop_front());
                    exp_cnt++;
                end
            end
        end
    end

    task automatic send(input int idx);
        bit acc = 0;
        Valid_in = 1'b1;
        Data_in  = vx[idx];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Ready_out) begin
                acc = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        else q.push_back(idx);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input int idx);
        send(idx);
        Valid_in = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", 32'(Valid_out), 32'd0);
        @(negedge clk);
        chk("lat_cycle2", 32'(Valid_out), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(Count_out), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        Valid_in = 1'b0;
        Data_in  = '0;
        Ready_in = 1'b0;
        #2;
        chk("rst_valid", 32'(Valid_out), 32'd0);
        chk("rst_out1", Data_out1, 32'd0);
        chk("rst_out2", Data_out2, 32'd0);
        chk("rst_flags", 32'(Flags_out), 32'd0);
        chk("rst_count", 32'(Count_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rdy_after_rst", 32'(Ready_out), 32'd1);
        Ready_in = 1'b1;

        one(0);
        drain("single");
        chk("single_count_is1", 32'(Count_out), 32'd1);

        send(1);
        chk("rdy_stream", 32'(Ready_out), 32'd1);
        send(0);
        chk("rdy_stream2", 32'(Ready_out), 32'd1);
        Valid_in = 1'b0;
        drain("stream");

        for (int i = 2; i < 10; i++) send(i);
        send(14);
        Valid_in = 1'b0;
        drain("specials");

        Ready_in = 1'b0;
        send(10);
        send(11);
        Valid_in = 1'b1;
        Data_in  = vx[12];
        repeat (3) begin
            @(negedge clk);
            chk("rdy_stall", 32'(Ready_out), 32'd0);
            @(posedge clk);
            #1;
        end
        Ready_in = 1'b1;
        send(12);
        send(13);
        Valid_in = 1'b0;
        drain("stall");

        Ready_in = 1'b0;
        send(2);
        send(3);
        Valid_in = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(Valid_out), 32'd0);
        chk("midrst_count", 32'(Count_out), 32'd0);
        q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        Ready_in = 1'b1;
        chk("rdy_after_midrst", 32'(Ready_out), 32'd1);
        one(4);
        drain("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
